// File: rtl/demux_frame_router.sv
`default_nettype none
// ============================================================================
//  Module      : demux_frame_router
//  Description : Front-end control for a 1-to-4 demux. Parses a framed serial
//                stream (2-bit channel address, MSB first, followed by
//                PAYLOAD_LEN payload bits). It holds the demux select steady
//                for the whole payload and strobes each payload bit out with
//                one cycle of latency.
//  Ports       : clk         - clock, rising edge
//                rst_n       - asynchronous active-low reset
//                din         - serial stream bit
//                din_valid   - qualifies din and sof
//                sof         - start of frame, marks din as the address MSB
//                a           - registered data bit to the demux
//                a_valid     - one-cycle strobe for a new payload bit on a
//                sel[0:1]    - registered demux select, sel[0] is the MSB
//                busy        - a frame is in progress
//                frame_done  - one-cycle pulse with the last payload strobe
//                err         - one-cycle pulse when a new sof aborts a frame
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_frame_router #(
  parameter int PAYLOAD_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       din_valid,
  input  logic       sof,
  output logic       a,
  output logic       a_valid,
  output logic [0:1] sel,
  output logic       busy,
  output logic       frame_done,
  output logic       err
);

  localparam int CW = $clog2(PAYLOAD_LEN + 1);
  localparam logic [CW-1:0] C_LAST_IDX = CW'(PAYLOAD_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ADDR    = 2'd1,
    S_PAYLOAD = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_addr_msb;

  // State is registered, so busy is glitch-free and rises the cycle after sof
  // is accepted and falls together with frame_done.
  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr_msb <= 1'b0;
      a          <= 1'b0;
      a_valid    <= 1'b0;
      sel        <= 2'b00;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      // Strobes default low; a, sel, counter and state hold on a stall.
      a_valid    <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      if (din_valid) begin
        case (r_state)
          S_IDLE: begin
            if (sof) begin
              r_addr_msb <= din;
              r_state    <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (sof) begin
              // Restart: this bit becomes the new address MSB.
              err        <= 1'b1;
              r_addr_msb <= din;
            end else begin
              sel     <= {r_addr_msb, din};
              r_cnt   <= '0;
              r_state <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            // Abort wins over completion, so test sof before the last index.
            if (sof) begin
              err        <= 1'b1;
              r_addr_msb <= din;
              r_cnt      <= '0;
              r_state    <= S_ADDR;
            end else begin
              a       <= din;
              a_valid <= 1'b1;
              r_cnt   <= r_cnt + CW'(1);
              if (r_cnt == C_LAST_IDX) begin
                frame_done <= 1'b1;
                r_state    <= S_IDLE;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_demux_frame_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_frame_router
//  Description : Self-checking bench for demux_frame_router. Expected payload
//                bits are queued as they are driven and popped whenever the
//                PAYLOAD_LEN=8 instance strobes a_valid. A second instance
//                with PAYLOAD_LEN=1 covers the single-bit payload corner.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_frame_router;

  logic       clk;
  logic       rst_n;
  logic       din, din_valid, sof;
  logic       a, a_valid, busy, frame_done, err;
  logic [0:1] sel;
  logic       d1, v1, s1;
  logic       a1, av1, busy1, fd1, err1;
  logic [0:1] sel1;

  int passed;
  int total;
  int fd_cnt;
  int err_cnt;
  int strobe_cnt;
  bit exp_q[$];

  demux_frame_router #(.PAYLOAD_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .a(a), .a_valid(a_valid), .sel(sel), .busy(busy),
    .frame_done(frame_done), .err(err)
  );

  demux_frame_router #(.PAYLOAD_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(d1), .din_valid(v1), .sof(s1),
    .a(a1), .a_valid(av1), .sel(sel1), .busy(busy1),
    .frame_done(fd1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus on the 8-bit instance; outputs sampled 1 time unit
  // after the edge. Any a_valid strobe pops and checks the scoreboard.
  task automatic cyc(input logic v, input logic s, input logic d, input bit push);
    din_valid = v;
    sof       = s;
    din       = d;
    if (push) exp_q.push_back(d);
    @(posedge clk);
    #1;
    if (a_valid) begin
      bit e;
      strobe_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL strobe_unexpected a=%0b required=no strobe", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) $display("FAIL payload_bit a=%0b required=%0b", a, e);
        else passed++;
      end
    end
    if (frame_done) fd_cnt++;
    if (err) err_cnt++;
  endtask

  task automatic clear_counts();
    fd_cnt = 0;
    err_cnt = 0;
    strobe_cnt = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    total++;
    if ({a, a_valid, sel, busy, frame_done, err} !== 7'b0)
      $display("FAIL reset_outputs got=%b required=0000000",
               {a, a_valid, sel, busy, frame_done, err});
    else passed++;
    total++;
    if ({a1, av1, sel1, busy1, fd1, err1} !== 7'b0)
      $display("FAIL reset_outputs_len1 got=%b required=0000000",
               {a1, av1, sel1, busy1, fd1, err1});
    else passed++;
  endtask

  task automatic test_basic();
    logic [7:0] p;
    p = 8'b1011_0010;
    clear_counts();
    cyc(1, 1, 1, 0);
    total++;
    if (busy !== 1'b1) $display("FAIL basic_busy_rise busy=%0b required=1", busy);
    else passed++;
    cyc(1, 0, 0, 0);
    total++;
    if (sel !== 2'b10) $display("FAIL basic_sel sel=%b required=10", sel);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, p[7-i], 1);
      if (i < 7) begin
        total++;
        if (frame_done !== 1'b0) $display("FAIL basic_early_done idx=%0d frame_done=1 required=0", i);
        else passed++;
      end
    end
    total++;
    if ({frame_done, a_valid, busy} !== 3'b110)
      $display("FAIL basic_last_bit done,valid,busy=%b required=110", {frame_done, a_valid, busy});
    else passed++;
    cyc(0, 0, 0, 0);
    total++;
    if ({a_valid, sel, a} !== 4'b0100)
      $display("FAIL basic_idle_hold valid,sel,a=%b required=0100", {a_valid, sel, a});
    else passed++;
    total++;
    if (strobe_cnt != 8 || fd_cnt != 1 || exp_q.size() != 0)
      $display("FAIL basic_counts strobes=%0d done=%0d left=%0d required=8,1,0",
               strobe_cnt, fd_cnt, exp_q.size());
    else passed++;
  endtask

  task automatic test_stall();
    logic [7:0] p;
    p = 8'b1011_0010;
    clear_counts();
    cyc(1, 1, 1, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, p[7-i], 1);
      if (i == 3) begin
        for (int k = 0; k < 3; k++) begin
          cyc(0, 0, ~p[7-i], 0);
          total++;
          if ({a, a_valid, frame_done} !== {p[4], 2'b00})
            $display("FAIL stall_hold a,valid,done=%b required=%b",
                     {a, a_valid, frame_done}, {p[4], 2'b00});
          else passed++;
        end
      end
    end
    total++;
    if (strobe_cnt != 8 || fd_cnt != 1 || frame_done !== 1'b1)
      $display("FAIL stall_counts strobes=%0d done=%0d last_done=%0b required=8,1,1",
               strobe_cnt, fd_cnt, frame_done);
    else passed++;
  endtask

  task automatic test_abort();
    clear_counts();
    cyc(1, 1, 0, 0);
    cyc(1, 0, 1, 0);
    total++;
    if (sel !== 2'b01) $display("FAIL abort_first_sel sel=%b required=01", sel);
    else passed++;
    for (int i = 0; i < 4; i++) cyc(1, 0, 1'(i & 1), 1);
    cyc(1, 1, 1, 0);
    total++;
    if ({err, a_valid, busy, frame_done} !== 4'b1010)
      $display("FAIL abort_err err,valid,busy,done=%b required=1010",
               {err, a_valid, busy, frame_done});
    else passed++;
    cyc(1, 0, 1, 0);
    total++;
    if ({sel, err} !== 3'b110) $display("FAIL abort_new_sel sel,err=%b required=110", {sel, err});
    else passed++;
    for (int i = 0; i < 8; i++) cyc(1, 0, 1'((i * 5) % 3 == 1), 1);
    total++;
    if (strobe_cnt != 12 || fd_cnt != 1 || err_cnt != 1)
      $display("FAIL abort_counts strobes=%0d done=%0d err=%0d required=12,1,1",
               strobe_cnt, fd_cnt, err_cnt);
    else passed++;
  endtask

  task automatic test_back_to_back();
    clear_counts();
    cyc(0, 1, 1, 0);
    total++;
    if ({busy, sel} !== 3'b011)
      $display("FAIL ignore_sof_novalid busy,sel=%b required=011", {busy, sel});
    else passed++;
    cyc(1, 0, 1, 0);
    total++;
    if (busy !== 1'b0) $display("FAIL ignore_valid_nosof busy=%0b required=0", busy);
    else passed++;
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    total++;
    if (sel !== 2'b00) $display("FAIL b2b_sel0 sel=%b required=00", sel);
    else passed++;
    for (int i = 0; i < 8; i++) cyc(1, 0, 1'(i % 3 == 0), 1);
    total++;
    if ({frame_done, busy} !== 2'b10)
      $display("FAIL b2b_first_done done,busy=%b required=10", {frame_done, busy});
    else passed++;
    cyc(1, 1, 1, 0);
    total++;
    if ({busy, sel} !== 3'b100)
      $display("FAIL b2b_second_sof busy,sel=%b required=100", {busy, sel});
    else passed++;
    cyc(1, 0, 1, 0);
    total++;
    if (sel !== 2'b11) $display("FAIL b2b_sel3 sel=%b required=11", sel);
    else passed++;
    for (int i = 0; i < 8; i++) cyc(1, 0, 1'(i % 2), 1);
    total++;
    if (fd_cnt != 2 || strobe_cnt != 16 || err_cnt != 0)
      $display("FAIL b2b_counts done=%0d strobes=%0d err=%0d required=2,16,0",
               fd_cnt, strobe_cnt, err_cnt);
    else passed++;
  endtask

  task automatic test_async_reset();
    clear_counts();
    cyc(1, 1, 1, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({a, a_valid, sel, busy, frame_done, err} !== 7'b0)
      $display("FAIL async_reset got=%b required=0000000",
               {a, a_valid, sel, busy, frame_done, err});
    else passed++;
    #2;
    rst_n = 1'b1;
    exp_q.delete();
    cyc(1, 0, 1, 0);
    total++;
    if (busy !== 1'b0) $display("FAIL post_reset_nosof busy=%0b required=0", busy);
    else passed++;
    fd_cnt = 0;
    cyc(1, 1, 0, 0);
    cyc(1, 0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 1'(i > 4), 1);
    total++;
    if ({sel, frame_done, busy} !== 4'b0110 || fd_cnt != 1)
      $display("FAIL post_reset_frame sel,done,busy=%b done_cnt=%0d required=0110,1",
               {sel, frame_done, busy}, fd_cnt);
    else passed++;
  endtask

  task automatic test_len1();
    v1 = 1; s1 = 1; d1 = 0;
    @(posedge clk); #1;
    total++;
    if (busy1 !== 1'b1) $display("FAIL len1_busy busy=%0b required=1", busy1);
    else passed++;
    s1 = 0; d1 = 1;
    @(posedge clk); #1;
    total++;
    if ({sel1, av1} !== 3'b010) $display("FAIL len1_sel sel,valid=%b required=010", {sel1, av1});
    else passed++;
    d1 = 1;
    @(posedge clk); #1;
    total++;
    if ({a1, av1, fd1, busy1} !== 4'b1110)
      $display("FAIL len1_strobe a,valid,done,busy=%b required=1110", {a1, av1, fd1, busy1});
    else passed++;
    v1 = 0;
    @(posedge clk); #1;
    total++;
    if ({av1, fd1, sel1} !== 4'b0001)
      $display("FAIL len1_after valid,done,sel=%b required=0001", {av1, fd1, sel1});
    else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    passed = 0;
    total = 0;
    din = 0; din_valid = 0; sof = 0;
    d1 = 0; v1 = 0; s1 = 0;
    clear_counts();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_stall();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_len1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
